// File: rtl/vga_timing_generator_if.sv
// Raster timing bundle between the VGA timing generator and its consumers.
// pix_en is a strobe, not a handshake: the generator advances exactly once per CLK with pix_en=1 and never stalls.
interface vga_timing_generator_if;
    logic       pix_en;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  pix_en,
        output x, y, active, hsync, vsync, blank_n, line_start, frame_start
    );

    modport slave (
        output pix_en,
        input  x, y, active, hsync, vsync, blank_n, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_generator.sv
// Raster scan counters for the 640x480@60 frame, with sync/blank outputs delayed by PIPE_DLY pixel stages
// so they line up with the downstream pixel pipeline.
module vga_timing_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vga_timing_generator_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = HS_LO + H_SYNC - 1;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = VS_LO + V_SYNC - 1;

    // The 10-bit coordinate ports cannot represent a longer raster.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_generator: H_TOTAL and V_TOTAL must each be <= 1024");
    end
    if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_dly
        $error("vga_timing_generator: PIPE_DLY must be in 1..4");
    end

    logic [9:0]          x_q;
    logic [9:0]          y_q;
    logic                x_wrap;
    logic                y_wrap;
    logic                hs_raw;
    logic                vs_raw;
    logic                active_raw;
    logic [PIPE_DLY-1:0] hs_pipe;
    logic [PIPE_DLY-1:0] vs_pipe;
    logic [PIPE_DLY-1:0] act_pipe;
    logic                line_start_q;
    logic                frame_start_q;

    assign x_wrap     = (x_q == 10'(H_TOTAL - 1));
    assign y_wrap     = (y_q == 10'(V_TOTAL - 1));
    assign hs_raw     = (x_q >= 10'(HS_LO)) && (x_q <= 10'(HS_HI));
    assign vs_raw     = (y_q >= 10'(VS_LO)) && (y_q <= 10'(VS_HI));
    assign active_raw = (x_q < 10'(H_ACTIVE)) && (y_q < 10'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            hs_pipe       <= '0;
            vs_pipe       <= '0;
            act_pipe      <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (vga.pix_en) begin
                line_start_q  <= x_wrap;
                frame_start_q <= x_wrap && y_wrap;
                if (x_wrap) begin
                    x_q <= '0;
                    y_q <= y_wrap ? 10'd0 : y_q + 10'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
                // Pipe stages hold "asserted" flags; polarity is applied only at the outputs.
                hs_pipe[0]  <= hs_raw;
                vs_pipe[0]  <= vs_raw;
                act_pipe[0] <= active_raw;
                for (int i = 1; i < PIPE_DLY; i++) begin
                    hs_pipe[i]  <= hs_pipe[i-1];
                    vs_pipe[i]  <= vs_pipe[i-1];
                    act_pipe[i] <= act_pipe[i-1];
                end
            end
        end
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.active      = active_raw;
    assign vga.hsync       = ~(hs_pipe[PIPE_DLY-1] ^ SYNC_POL);
    assign vga.vsync       = ~(vs_pipe[PIPE_DLY-1] ^ SYNC_POL);
    assign vga.blank_n     = act_pipe[PIPE_DLY-1];
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a full-size instance for line/sync timing and a tiny-raster instance
// (active-high syncs, 3-stage delay) so whole frames fit in a short run.
module tb_vga_timing_generator;
    localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
    localparam int A_VA = 480, A_VFP = 10, A_VS = 2,  A_VBP = 33;
    localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
    localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;
    localparam int A_DLY = 2;
    localparam bit A_POL = 1'b0;

    localparam int B_HA = 8, B_HFP = 2, B_HS = 3, B_HBP = 2;
    localparam int B_VA = 4, B_VFP = 1, B_VS = 2, B_VBP = 2;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
    localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;
    localparam int B_DLY = 3;
    localparam bit B_POL = 1'b1;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    always #10 clk = ~clk;

    vga_timing_generator_if a_if ();
    vga_timing_generator_if b_if ();

    vga_timing_generator dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .vga   (a_if)
    );

    vga_timing_generator #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .SYNC_POL(B_POL), .PIPE_DLY(B_DLY)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .vga   (b_if)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pixel index within the frame plus strobes seen since reset.
    int ma_p = 0, ma_hist = 0;
    bit ma_ls = 0, ma_fs = 0;
    int mb_p = 0, mb_hist = 0;
    bit mb_ls = 0, mb_fs = 0;

    // Delayed outputs show the pixel PIPE_DLY strobes back; before that many strobes, the reset values.
    function automatic logic [2:0] exp_dly(int p, int hist, int ht, int vt, int ha, int va,
                                           int hs_lo, int hs_n, int vs_lo, int vs_n, int dly, bit pol);
        int q, col, row;
        logic hs, vs, bl;
        if (hist < dly) return {~pol, ~pol, 1'b0};
        q   = (p - dly + ht * vt) % (ht * vt);
        col = q % ht;
        row = q / ht;
        hs  = (col >= hs_lo) && (col < hs_lo + hs_n);
        vs  = (row >= vs_lo) && (row < vs_lo + vs_n);
        bl  = (col < ha) && (row < va);
        return {hs ? pol : ~pol, vs ? pol : ~pol, bl};
    endfunction

    function automatic logic [2:0] exp_a_dly();
        return exp_dly(ma_p, ma_hist, A_HT, A_VT, A_HA, A_VA, A_HA + A_HFP, A_HS, A_VA + A_VFP, A_VS, A_DLY, A_POL);
    endfunction

    function automatic logic [2:0] exp_b_dly();
        return exp_dly(mb_p, mb_hist, B_HT, B_VT, B_HA, B_VA, B_HA + B_HFP, B_HS, B_VA + B_VFP, B_VS, B_DLY, B_POL);
    endfunction

    // driver tasks: drive, clock, advance the model, then sample 1ns after the edge
    task automatic step_a(input bit pe, input bit rst);
        a_if.pix_en = pe;
        rst_n_a     = ~rst;
        @(posedge clk);
        if (rst) begin
            ma_p = 0; ma_hist = 0; ma_ls = 0; ma_fs = 0;
        end else if (pe) begin
            ma_ls = ((ma_p % A_HT) == A_HT - 1);
            ma_fs = (ma_p == A_HT * A_VT - 1);
            ma_p  = (ma_p + 1) % (A_HT * A_VT);
            if (ma_hist < 8) ma_hist++;
        end else begin
            ma_ls = 0; ma_fs = 0;
        end
        #1;
    endtask

    task automatic step_b(input bit pe, input bit rst);
        b_if.pix_en = pe;
        rst_n_b     = ~rst;
        @(posedge clk);
        if (rst) begin
            mb_p = 0; mb_hist = 0; mb_ls = 0; mb_fs = 0;
        end else if (pe) begin
            mb_ls = ((mb_p % B_HT) == B_HT - 1);
            mb_fs = (mb_p == B_HT * B_VT - 1);
            mb_p  = (mb_p + 1) % (B_HT * B_VT);
            if (mb_hist < 8) mb_hist++;
        end else begin
            mb_ls = 0; mb_fs = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        step_a(1'b1, 1'b1);
        step_a(1'b1, 1'b1);
        checks++; if (a_if.x !== 10'd0) begin errors++; $display("FAIL reset_x got=%0d exp=0", a_if.x); end
        checks++; if (a_if.y !== 10'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", a_if.y); end
        checks++; if (a_if.active !== 1'b1) begin errors++; $display("FAIL reset_active got=%b exp=1", a_if.active); end
        checks++; if ({a_if.hsync, a_if.vsync, a_if.blank_n} !== 3'b110)
            begin errors++; $display("FAIL reset_sync_blank got=%b exp=110", {a_if.hsync, a_if.vsync, a_if.blank_n}); end
        checks++; if ({a_if.line_start, a_if.frame_start} !== 2'b00)
            begin errors++; $display("FAIL reset_pulses got=%b exp=00", {a_if.line_start, a_if.frame_start}); end
        for (int k = 1; k <= 2; k++) begin
            step_a(1'b1, 1'b0);
            checks++; if (a_if.blank_n !== exp_a_dly()[0])
                begin errors++; $display("FAIL reset_blank_step%0d got=%b exp=%b", k, a_if.blank_n, exp_a_dly()[0]); end
        end
        checks++; if (a_if.blank_n !== 1'b1) begin errors++; $display("FAIL blank_after_2 got=%b exp=1", a_if.blank_n); end
    endtask

    task automatic test_hsync();
        logic prev;
        int fall = -1, rise = -1;
        step_a(1'b1, 1'b1);
        prev = a_if.hsync;
        for (int k = 1; k <= 800; k++) begin
            step_a(1'b1, 1'b0);
            checks++; if (a_if.hsync !== exp_a_dly()[2])
                begin errors++; $display("FAIL hsync_step%0d got=%b exp=%b", k, a_if.hsync, exp_a_dly()[2]); end
            if (prev === 1'b1 && a_if.hsync === 1'b0 && fall < 0) fall = k;
            if (prev === 1'b0 && a_if.hsync === 1'b1 && rise < 0) rise = k;
            prev = a_if.hsync;
        end
        checks++; if (fall != 658) begin errors++; $display("FAIL hsync_fall_strobe got=%0d exp=658", fall); end
        checks++; if (rise != 754) begin errors++; $display("FAIL hsync_rise_strobe got=%0d exp=754", rise); end
        checks++; if (rise - fall != 96) begin errors++; $display("FAIL hsync_width got=%0d exp=96", rise - fall); end
    endtask

    task automatic test_line_wrap();
        int n = 0;
        while (ma_p != 9 * A_HT + 799 && n < 10000) begin step_a(1'b1, 1'b0); n++; end
        checks++; if (a_if.x !== 10'd799 || a_if.y !== 10'd9)
            begin errors++; $display("FAIL line_pre_xy got=%0d,%0d exp=799,9", a_if.x, a_if.y); end
        step_a(1'b1, 1'b0);
        checks++; if (a_if.x !== 10'd0 || a_if.y !== 10'd10)
            begin errors++; $display("FAIL line_wrap_xy got=%0d,%0d exp=0,10", a_if.x, a_if.y); end
        checks++; if (a_if.line_start !== 1'b1) begin errors++; $display("FAIL line_start_pulse got=%b exp=1", a_if.line_start); end
        checks++; if (a_if.frame_start !== 1'b0) begin errors++; $display("FAIL line_no_frame got=%b exp=0", a_if.frame_start); end
        step_a(1'b0, 1'b0);
        checks++; if (a_if.line_start !== 1'b0) begin errors++; $display("FAIL line_start_width got=%b exp=0", a_if.line_start); end
        checks++; if (a_if.x !== 10'd0) begin errors++; $display("FAIL line_hold_x got=%0d exp=0", a_if.x); end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        while ((ma_p % A_HT) != 300 && n < 1000) begin step_a(1'b1, 1'b0); n++; end
        checks++; if (a_if.x !== 10'd300) begin errors++; $display("FAIL midrst_pre_x got=%0d exp=300", a_if.x); end
        step_a(1'b1, 1'b1);
        checks++; if (a_if.x !== 10'd0 || a_if.y !== 10'd0)
            begin errors++; $display("FAIL midrst_xy got=%0d,%0d exp=0,0", a_if.x, a_if.y); end
        checks++; if ({a_if.hsync, a_if.vsync, a_if.blank_n} !== 3'b110)
            begin errors++; $display("FAIL midrst_sync_blank got=%b exp=110", {a_if.hsync, a_if.vsync, a_if.blank_n}); end
        checks++; if ({a_if.line_start, a_if.frame_start} !== 2'b00)
            begin errors++; $display("FAIL midrst_pulses got=%b exp=00", {a_if.line_start, a_if.frame_start}); end
        step_a(1'b1, 1'b0);
        checks++; if (a_if.frame_start !== 1'b0 || a_if.x !== 10'd1)
            begin errors++; $display("FAIL midrst_release got=fs%b,x%0d exp=fs0,x1", a_if.frame_start, a_if.x); end
    endtask

    task automatic test_half_rate();
        logic [9:0] px, py;
        logic phs;
        int f1 = -1, f2 = -1;
        bit pe;
        step_a(1'b1, 1'b1);
        px = a_if.x; py = a_if.y; phs = a_if.hsync;
        for (int c = 0; c < 3400; c++) begin
            pe = (c % 2 == 0);
            step_a(pe, 1'b0);
            checks++; if (a_if.x !== 10'(ma_p % A_HT) || a_if.y !== 10'(ma_p / A_HT))
                begin errors++; $display("FAIL half_xy c=%0d got=%0d,%0d exp=%0d,%0d", c, a_if.x, a_if.y, ma_p % A_HT, ma_p / A_HT); end
            if (!pe) begin
                checks++; if (a_if.x !== px || a_if.y !== py || a_if.hsync !== phs || a_if.line_start !== 1'b0)
                    begin errors++; $display("FAIL half_hold c=%0d got=%0d,%0d,%b exp=%0d,%0d,%b", c, a_if.x, a_if.y, a_if.hsync, px, py, phs); end
            end
            if (phs === 1'b1 && a_if.hsync === 1'b0) begin
                if (f1 < 0) f1 = c; else if (f2 < 0) f2 = c;
            end
            px = a_if.x; py = a_if.y; phs = a_if.hsync;
        end
        checks++; if (f1 < 0 || f2 < 0 || f2 - f1 != 1600)
            begin errors++; $display("FAIL half_hsync_period got=%0d exp=1600 (edges %0d,%0d)", f2 - f1, f1, f2); end
    endtask

    task automatic test_random_a();
        bit pe, rst;
        step_a(1'b1, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            pe  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step_a(pe, rst);
            checks++; if (a_if.x !== 10'(ma_p % A_HT) || a_if.y !== 10'(ma_p / A_HT))
                begin errors++; $display("FAIL rnda_xy c=%0d got=%0d,%0d exp=%0d,%0d", c, a_if.x, a_if.y, ma_p % A_HT, ma_p / A_HT); end
            checks++; if (a_if.active !== ((ma_p % A_HT) < A_HA && (ma_p / A_HT) < A_VA))
                begin errors++; $display("FAIL rnda_active c=%0d got=%b", c, a_if.active); end
            checks++; if ({a_if.hsync, a_if.vsync, a_if.blank_n} !== exp_a_dly())
                begin errors++; $display("FAIL rnda_dly c=%0d got=%b exp=%b", c, {a_if.hsync, a_if.vsync, a_if.blank_n}, exp_a_dly()); end
            checks++; if ({a_if.line_start, a_if.frame_start} !== {ma_ls, ma_fs})
                begin errors++; $display("FAIL rnda_pulses c=%0d got=%b exp=%b", c, {a_if.line_start, a_if.frame_start}, {ma_ls, ma_fs}); end
        end
    endtask

    task automatic test_frame_wrap();
        int n = 0;
        step_b(1'b1, 1'b1);
        while (mb_p != B_HT * B_VT - 1 && n < 1000) begin step_b(1'b1, 1'b0); n++; end
        checks++; if (b_if.x !== 10'(B_HT - 1) || b_if.y !== 10'(B_VT - 1))
            begin errors++; $display("FAIL frame_pre_xy got=%0d,%0d exp=%0d,%0d", b_if.x, b_if.y, B_HT - 1, B_VT - 1); end
        step_b(1'b1, 1'b0);
        checks++; if (b_if.x !== 10'd0 || b_if.y !== 10'd0)
            begin errors++; $display("FAIL frame_wrap_xy got=%0d,%0d exp=0,0", b_if.x, b_if.y); end
        checks++; if ({b_if.line_start, b_if.frame_start} !== 2'b11)
            begin errors++; $display("FAIL frame_pulses got=%b exp=11", {b_if.line_start, b_if.frame_start}); end
        n = 0;
        do begin step_b(1'b1, 1'b0); n++; end while (b_if.frame_start !== 1'b1 && n < 300);
        checks++; if (n != B_HT * B_VT)
            begin errors++; $display("FAIL frame_period got=%0d exp=%0d", n, B_HT * B_VT); end
    endtask

    task automatic test_random_b();
        bit pe, rst;
        step_b(1'b1, 1'b1);
        for (int c = 0; c < 1500; c++) begin
            pe  = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 399) == 0);
            step_b(pe, rst);
            checks++; if (b_if.x !== 10'(mb_p % B_HT) || b_if.y !== 10'(mb_p / B_HT))
                begin errors++; $display("FAIL rndb_xy c=%0d got=%0d,%0d exp=%0d,%0d", c, b_if.x, b_if.y, mb_p % B_HT, mb_p / B_HT); end
            checks++; if (b_if.active !== ((mb_p % B_HT) < B_HA && (mb_p / B_HT) < B_VA))
                begin errors++; $display("FAIL rndb_active c=%0d got=%b", c, b_if.active); end
            checks++; if ({b_if.hsync, b_if.vsync, b_if.blank_n} !== exp_b_dly())
                begin errors++; $display("FAIL rndb_dly c=%0d got=%b exp=%b", c, {b_if.hsync, b_if.vsync, b_if.blank_n}, exp_b_dly()); end
            checks++; if ({b_if.line_start, b_if.frame_start} !== {mb_ls, mb_fs})
                begin errors++; $display("FAIL rndb_pulses c=%0d got=%b exp=%b", c, {b_if.line_start, b_if.frame_start}, {mb_ls, mb_fs}); end
        end
    endtask

    initial begin
        a_if.pix_en = 1'b0;
        b_if.pix_en = 1'b0;
        test_reset();
        test_hsync();
        test_line_wrap();
        test_mid_reset();
        test_half_rate();
        test_random_a();
        test_frame_wrap();
        test_random_b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
